// File: rtl/lap_pkg.sv
// Shared constants, types and helpers for the lap-record playback path.
package lap_pkg;

    localparam int WIDTH   = 13;    // record width in bits
    localparam int DEPTH   = 9;     // number of record slots
    localparam int MAX_VAL = 6000;  // saturation value, 60.00 s
    localparam int BCD_W   = 16;    // four BCD digits

    typedef logic [3:0] bcd_digit_t;

    // Playback FSM encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_CONV  = 3'd3;
    localparam state_t ST_SHOW  = 3'd4;

    // Double-dabble correction: every digit of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one shift-add-3 per cycle, WIDTH cycles per value.
// A load restarts the conversion; done pulses for one cycle with bcd final.
module bin2bcd_seq
    import lap_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic             done_q;

    // Correct the BCD scratch before the next shift.
    // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
    always_comb begin
        bcd_adj = bcd_adjust(bcd_q);
    end

    // Load, then shift the binary value MSB-first into the BCD scratch.
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (load) begin
            shift_q  <= bin;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
            done_q   <= 1'b0;
        end else if (active_q) begin
            bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                active_q <= 1'b0;
                done_q   <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/lap_playback.sv
// Lap-record playback: fetches a record, converts it to BCD and shows it with
// its 1-based index; supports manual stepping and timed auto-scroll.
module lap_playback
    import lap_pkg::*;
#(
    parameter int DWELL_TICKS = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             auto_en,
    input  logic [3:0]       rec_count,
    output logic             rd_en,
    output logic [3:0]       rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic [3:0]       digit3,
    output logic [3:0]       digit2,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0,
    output logic [3:0]       idx,
    output logic             disp_valid,
    output logic             busy
);

    localparam int DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_TICKS - 1);

    state_t           state_q;
    logic [3:0]       addr_q;
    logic [DW_W-1:0]  dwell_q;
    logic             rd_en_q;
    bcd_digit_t       d3_q, d2_q, d1_q, d0_q;
    logic [3:0]       idx_q;
    logic             valid_q;

    logic [WIDTH-1:0] sat_data;
    logic [3:0]       addr_inc;
    logic [3:0]       next_addr;
    logic             abort;
    logic             auto_fire;
    logic             conv_load;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    // Saturation, wrap address and the advance/abort conditions.
    always_comb begin
        sat_data = rd_data;
        if (rd_data > WIDTH'(MAX_VAL)) sat_data = WIDTH'(MAX_VAL);
        addr_inc  = addr_q + 4'd1;
        next_addr = (addr_inc >= rec_count) ? 4'd0 : addr_inc;
        // An empty store (stopwatch reset) behaves exactly like stop.
        abort     = stop || (rec_count == 4'd0);
        auto_fire = auto_en && tick && (dwell_q == DWELL_LAST);
        conv_load = (state_q == ST_WAIT);
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .load  (conv_load),
        .bin   (sat_data),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Playback FSM, address/wrap register, dwell counter and display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            dwell_q <= '0;
            rd_en_q <= 1'b0;
            d3_q    <= '0;
            d2_q    <= '0;
            d1_q    <= '0;
            d0_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (abort) begin
            // Any conversion in flight is simply ignored from IDLE.
            state_q <= ST_IDLE;
            addr_q  <= '0;
            dwell_q <= '0;
            rd_en_q <= 1'b0;
            d3_q    <= '0;
            d2_q    <= '0;
            d1_q    <= '0;
            d0_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= '0;
                        rd_en_q <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_q <= ST_CONV;
                end
                ST_CONV: begin
                    if (conv_done) begin
                        d3_q    <= conv_bcd[15:12];
                        d2_q    <= conv_bcd[11:8];
                        d1_q    <= conv_bcd[7:4];
                        d0_q    <= conv_bcd[3:0];
                        idx_q   <= addr_q + 4'd1;
                        valid_q <= 1'b1;
                        dwell_q <= '0;
                        state_q <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (start) begin
                        addr_q  <= '0;
                        dwell_q <= '0;
                        rd_en_q <= 1'b1;
                        state_q <= ST_FETCH;
                    end else if (step || auto_fire) begin
                        addr_q  <= next_addr;
                        dwell_q <= '0;
                        rd_en_q <= 1'b1;
                        state_q <= ST_FETCH;
                    end else if (!auto_en) begin
                        dwell_q <= '0;
                    end else if (tick) begin
                        dwell_q <= dwell_q + DW_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = addr_q;
    assign digit3     = d3_q;
    assign digit2     = d2_q;
    assign digit1     = d1_q;
    assign digit0     = d0_q;
    assign idx        = idx_q;
    assign disp_valid = valid_q;
    assign busy       = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_CONV);

endmodule

// File: tb/tb_lap_playback.sv
// Self-checking bench for lap_playback with a behavioural record RAM and a
// display model computed from the record values with plain decimal arithmetic.
module tb_lap_playback;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        start;
    logic        stop;
    logic        step;
    logic        auto_en;
    logic [3:0]  rec_count;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [12:0] rd_data;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic [3:0]  idx;
    logic        disp_valid;
    logic        busy;

    logic [12:0] mem [9];

    int n_cmp = 0;
    int n_err = 0;

    // Expected display contents: saturated value, index, valid flag.
    int exp_val   = 0;
    int exp_idx   = 0;
    int exp_valid = 0;

    int rc;
    int a;
    int k;
    logic seen_rd;

    lap_playback #(.DWELL_TICKS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .auto_en    (auto_en),
        .rec_count  (rec_count),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .digit3     (digit3),
        .digit2     (digit2),
        .digit1     (digit1),
        .digit0     (digit0),
        .idx        (idx),
        .disp_valid (disp_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en && rd_addr < 4'd9) rd_data <= mem[rd_addr];
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag);
        check({tag, "_d3"}, digit3, exp_val / 1000);
        check({tag, "_d2"}, digit2, (exp_val / 100) % 10);
        check({tag, "_d1"}, digit1, (exp_val / 10) % 10);
        check({tag, "_d0"}, digit0, exp_val % 10);
        check({tag, "_idx"}, idx, exp_idx);
        check({tag, "_valid"}, disp_valid, exp_valid);
    endtask

    task automatic set_expect(input int addr);
        exp_val   = (int'(mem[addr]) > 6000) ? 6000 : int'(mem[addr]);
        exp_idx   = addr + 1;
        exp_valid = 1;
    endtask

    task automatic clear_expect();
        exp_val   = 0;
        exp_idx   = 0;
        exp_valid = 0;
    endtask

    // Called right after the edge that launched a fetch of 'addr'. poke=1 pulses
    // step and poke=2 pulses start while busy; both must be ignored.
    task automatic run_fetch(input string tag, input int addr, input int poke);
        check({tag, "_rd_en"}, rd_en, 1);
        check({tag, "_rd_addr"}, rd_addr, addr);
        check({tag, "_busy"}, busy, 1);
        for (int c = 1; c <= 15; c++) begin
            if (c == 4 && poke == 1) step = 1'b1;
            if (c == 4 && poke == 2) start = 1'b1;
            tick_clk();
            step  = 1'b0;
            start = 1'b0;
        end
        check_disp({tag, "_hold"});
        check({tag, "_busy_late"}, busy, 1);
        tick_clk();
        set_expect(addr);
        check_disp(tag);
        check({tag, "_idle"}, busy, 0);
        if (poke != 0) begin
            tick_clk();
            tick_clk();
            check({tag, "_no_queue"}, busy, 0);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        tick_clk();
        tick = 1'b0;
        tick_clk();
    endtask

    task automatic fire_tick();
        tick = 1'b1;
        tick_clk();
        tick = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick_clk();
        step = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick_clk();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        step = 1'b0;
        auto_en = 1'b0;
        rec_count = 4'd0;
        for (int i = 0; i < 9; i++) mem[i] = 13'($urandom_range(0, 8191));
        repeat (3) tick_clk();
        check("reset_outputs", {rd_en, rd_addr, digit3, digit2, digit1, digit0, idx, disp_valid, busy}, 0);
        reset = 1'b0;
        tick_clk();

        // Basic playback and manual stepping over three records.
        mem[0] = 13'd1234;
        mem[1] = 13'd5999;
        mem[2] = 13'd7;
        rc = 3;
        rec_count = 4'(rc);
        do_start();
        run_fetch("start_r0", 0, 0);
        do_step();
        run_fetch("step_r1", 1, 1);
        do_step();
        run_fetch("step_r2", 2, 2);
        do_step();
        run_fetch("step_wrap_r0", 0, 0);

        // Reset in the middle of a conversion.
        do_start();
        repeat (6) tick_clk();
        reset = 1'b1;
        tick_clk();
        check("reset_mid_conv", {rd_en, rd_addr, digit3, digit2, digit1, digit0, idx, disp_valid, busy}, 0);
        reset = 1'b0;
        clear_expect();
        rec_count = 4'd0;
        do_start();
        seen_rd = 1'b0;
        repeat (20) begin
            tick_clk();
            if (rd_en) seen_rd = 1'b1;
        end
        check("empty_start_no_rd", seen_rd, 0);
        check("empty_start_idx", idx, 0);

        // Auto-scroll over random records with a random record count.
        for (int i = 0; i < 9; i++) mem[i] = 13'($urandom_range(0, 8191));
        rc = $urandom_range(3, 9);
        rec_count = 4'(rc);
        a = 0;
        do_start();
        run_fetch("auto_r0", a, 0);
        auto_en = 1'b1;
        pulse_tick();
        pulse_tick();
        check("auto_two_ticks_hold", busy, 0);
        fire_tick();
        a = (a + 1) % rc;
        run_fetch("auto_third_tick", a, 0);
        pulse_tick();
        pulse_tick();
        do_step();
        a = (a + 1) % rc;
        run_fetch("auto_step_after_two", a, 0);
        pulse_tick();
        pulse_tick();
        check("auto_dwell_restart", busy, 0);
        auto_en = 1'b0;
        tick_clk();
        auto_en = 1'b1;
        pulse_tick();
        pulse_tick();
        check("auto_drop_clears", busy, 0);
        fire_tick();
        a = (a + 1) % rc;
        run_fetch("auto_after_drop", a, 0);
        auto_en = 1'b0;
        repeat (5) pulse_tick();
        check("auto_off_no_adv", busy, 0);
        auto_en = 1'b1;
        for (int it = 0; it < 6; it++) begin
            k = $urandom_range(0, 2);
            repeat (k) pulse_tick();
            if ($urandom_range(0, 1) == 1) begin
                do_step();
            end else begin
                repeat (2 - k) pulse_tick();
                fire_tick();
            end
            a = (a + 1) % rc;
            run_fetch("auto_rand", a, 0);
        end
        auto_en = 1'b0;

        // Saturation, shrinking record count and start-over-step priority.
        mem[0] = 13'd8000;
        mem[1] = 13'($urandom_range(6001, 8191));
        mem[2] = 13'($urandom_range(0, 6000));
        rc = 3;
        rec_count = 4'(rc);
        do_start();
        run_fetch("sat_r0", 0, 0);
        do_step();
        run_fetch("sat_r1", 1, 0);
        do_step();
        run_fetch("sat_r2", 2, 0);
        rec_count = 4'd2;
        repeat (3) tick_clk();
        check_disp("shrink_keep");
        do_step();
        run_fetch("shrink_wrap", 0, 0);
        rec_count = 4'd3;
        step = 1'b1;
        start = 1'b1;
        tick_clk();
        step = 1'b0;
        start = 1'b0;
        run_fetch("start_beats_step", 0, 0);

        // Abort: record count falls to zero while showing.
        rec_count = 4'd0;
        tick_clk();
        clear_expect();
        check_disp("rc_zero_abort");
        check("rc_zero_busy", busy, 0);
        rec_count = 4'd3;

        // Abort: stop during FETCH after a record was shown.
        do_start();
        run_fetch("pre_stop_r0", 0, 0);
        do_start();
        stop = 1'b1;
        tick_clk();
        stop = 1'b0;
        clear_expect();
        check_disp("stop_fetch");
        seen_rd = 1'b0;
        repeat (20) begin
            tick_clk();
            if (rd_en || disp_valid || busy) seen_rd = 1'b1;
        end
        check("stop_fetch_quiet", seen_rd, 0);

        // Abort: stop during CONV discards the conversion.
        do_start();
        run_fetch("pre_stop_conv", 0, 0);
        do_start();
        repeat (7) tick_clk();
        stop = 1'b1;
        tick_clk();
        stop = 1'b0;
        clear_expect();
        check_disp("stop_conv");
        seen_rd = 1'b0;
        repeat (20) begin
            tick_clk();
            if (disp_valid || busy) seen_rd = 1'b1;
        end
        check("stop_conv_discard", seen_rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
